// File: rtl/rx_line_editor.sv
// Line capture between UART RX and command RAM: stores bytes from a programmable
// base, applies backspace/delete editing, bounds the length and NUL-terminates.
module rx_line_editor #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned MAX_LEN    = 64,
   parameter logic [7:0]  TERM_CHAR  = 8'h0D,
   parameter logic [7:0]  BS_CHAR    = 8'h08,
   parameter logic [7:0]  DEL_CHAR   = 8'h7F,
   parameter bit          IGNORE_LF  = 1'b1,
   localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1)
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_start_addr,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_done,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [7:0]            o_data,
   output logic                  o_write,
   output logic                  o_rx_line_done,
   output logic [LEN_W-1:0]      o_line_len,
   output logic                  o_overflow,
   output logic                  o_busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

   state_t                  r_state;
   logic                    r_rx_done_q;
   logic [ADDR_WIDTH-1:0]   r_base;
   logic [LEN_W-1:0]        r_count;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [7:0]              r_data;
   logic                    r_write;
   logic                    r_line_done;
   logic [LEN_W-1:0]        r_line_len;
   logic                    r_overflow;

   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   w_base_nxt;
   logic [LEN_W-1:0]        w_count_nxt;
   logic [ADDR_WIDTH-1:0]   w_addr_nxt;
   logic [7:0]              w_data_nxt;
   logic                    w_write_nxt;
   logic                    w_line_done_nxt;
   logic [LEN_W-1:0]        w_line_len_nxt;
   logic                    w_overflow_nxt;

   logic                    w_byte_evt;
   logic [ADDR_WIDTH-1:0]   w_wr_addr;
   logic                    w_is_erase;
   logic                    w_is_lf_drop;

   assign w_byte_evt   = i_rx_done & ~r_rx_done_q;
   // Truncation to ADDR_WIDTH gives the wrap past the top of RAM.
   assign w_wr_addr    = r_base + ADDR_WIDTH'(r_count);
   assign w_is_erase   = (i_rx_data == BS_CHAR) || (i_rx_data == DEL_CHAR);
   assign w_is_lf_drop = IGNORE_LF && (i_rx_data == 8'h0A);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_rx_done_q <= 1'b1;
         r_base      <= '0;
         r_count     <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_write     <= 1'b0;
         r_line_done <= 1'b0;
         r_line_len  <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rx_done_q <= i_rx_done;
         r_base      <= w_base_nxt;
         r_count     <= w_count_nxt;
         r_addr      <= w_addr_nxt;
         r_data      <= w_data_nxt;
         r_write     <= w_write_nxt;
         r_line_done <= w_line_done_nxt;
         r_line_len  <= w_line_len_nxt;
         r_overflow  <= w_overflow_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_base_nxt      = r_base;
      w_count_nxt     = r_count;
      w_addr_nxt      = r_addr;
      w_data_nxt      = r_data;
      w_write_nxt     = 1'b0;
      w_line_done_nxt = r_line_done;
      w_line_len_nxt  = r_line_len;
      w_overflow_nxt  = r_overflow;

      // start wins over a simultaneous byte, which is discarded.
      if (i_start) begin
         w_base_nxt      = i_start_addr;
         w_count_nxt     = '0;
         w_overflow_nxt  = 1'b0;
         w_line_done_nxt = 1'b0;
         w_state_nxt     = S_WAIT;
      end else if (r_state == S_WAIT && w_byte_evt) begin
         if (i_rx_data == TERM_CHAR) begin
            w_write_nxt     = 1'b1;
            w_addr_nxt      = w_wr_addr;
            w_data_nxt      = 8'h00;
            w_line_len_nxt  = r_count;
            w_line_done_nxt = 1'b1;
            w_state_nxt     = S_DONE;
         end else if (w_is_erase) begin
            if (r_count != '0) begin
               w_count_nxt = r_count - 1'b1;
            end
         end else if (w_is_lf_drop) begin
            w_count_nxt = r_count;
         end else if (r_count < MAX_CNT) begin
            w_write_nxt = 1'b1;
            w_addr_nxt  = w_wr_addr;
            w_data_nxt  = i_rx_data;
            w_count_nxt = r_count + 1'b1;
         end else begin
            w_overflow_nxt = 1'b1;
         end
      end
   end

   assign o_addr         = r_addr;
   assign o_data         = r_data;
   assign o_write        = r_write;
   assign o_rx_line_done = r_line_done;
   assign o_line_len     = r_line_len;
   assign o_overflow     = r_overflow;
   assign o_busy         = (r_state == S_WAIT);

endmodule

// File: tb/tb_rx_line_editor.sv
// Bench for rx_line_editor: drives byte streams with random timing and compares
// the captured RAM image and write sequence against a queue-based line model.
module tb_rx_line_editor;

   localparam int unsigned AW   = 8;
   localparam int unsigned MAXL = 6;
   localparam int unsigned LW   = $clog2(MAXL + 1);

   typedef logic [7:0] bq_t[$];

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [7:0]    rx_data;
   logic          rx_done;
   logic [AW-1:0] o_addr;
   logic [7:0]    o_data;
   logic          o_write;
   logic          o_rx_line_done;
   logic [LW-1:0] o_line_len;
   logic          o_overflow;
   logic          o_busy;

   always #5 clk = ~clk;

   rx_line_editor #(
      .ADDR_WIDTH(AW),
      .MAX_LEN   (MAXL),
      .TERM_CHAR (8'h0D),
      .BS_CHAR   (8'h08),
      .DEL_CHAR  (8'h7F),
      .IGNORE_LF (1'b1)
   ) dut (
      .i_clock       (clk),
      .i_reset       (reset),
      .i_start       (start),
      .i_start_addr  (start_addr),
      .i_rx_data     (rx_data),
      .i_rx_done     (rx_done),
      .o_addr        (o_addr),
      .o_data        (o_data),
      .o_write       (o_write),
      .o_rx_line_done(o_rx_line_done),
      .o_line_len    (o_line_len),
      .o_overflow    (o_overflow),
      .o_busy        (o_busy)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0]  ram     [256];
   logic [7:0]  exp_ram [256];
   logic [15:0] wr_log[$];
   logic [15:0] exp_wr[$];
   bit          consec = 1'b0;
   logic        prev_wr = 1'b0;
   int          exp_len;
   bit          exp_ovf;
   bit          exp_done;

   // RAM behind the editor, sampled mid-cycle.
   always @(negedge clk) begin
      if (o_write === 1'b1) begin
         wr_log.push_back({o_addr, o_data});
         ram[o_addr] = o_data;
         if (prev_wr === 1'b1) consec = 1'b1;
      end
      prev_wr = o_write;
   end

   // Reference: the stored line is a queue; each stored char lands at base+position.
   task automatic model_line(input logic [7:0] base, input bq_t s);
      logic [7:0] line[$];
      logic [7:0] a;
      exp_wr.delete();
      exp_ovf  = 1'b0;
      exp_done = 1'b0;
      foreach (s[i]) begin
         if (exp_done) break;
         a = base + 8'(line.size());
         if (s[i] == 8'h0D) begin
            exp_wr.push_back({a, 8'h00});
            exp_ram[a] = 8'h00;
            exp_len  = line.size();
            exp_done = 1'b1;
         end else if (s[i] == 8'h08 || s[i] == 8'h7F) begin
            if (line.size() > 0) void'(line.pop_back());
         end else if (s[i] == 8'h0A) begin
            // dropped
         end else if (line.size() < MAXL) begin
            exp_wr.push_back({a, s[i]});
            exp_ram[a] = s[i];
            line.push_back(s[i]);
         end else begin
            exp_ovf = 1'b1;
         end
      end
   endtask

   function automatic int log_diff();
      if (wr_log.size() != exp_wr.size()) return 1;
      foreach (wr_log[i]) if (wr_log[i] !== exp_wr[i]) return 1;
      return 0;
   endfunction

   function automatic int ram_diff();
      int c = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) c++;
      return c;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick($urandom_range(1, 3));
      rx_done = 1'b0;
      tick($urandom_range(1, 3));
   endtask

   task automatic do_start(input logic [7:0] base);
      start      = 1'b1;
      start_addr = base;
      tick(1);
      start      = 1'b0;
   endtask

   task automatic run_line(input logic [7:0] base, input bq_t s);
      wr_log.delete();
      do_start(base);
      foreach (s[i]) send_byte(s[i]);
      tick(2);
      model_line(base, s);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; start_addr = '0; rx_data = 8'h41; rx_done = 1'b1;
      tick(3);
      total++;
      if ({o_addr, o_data, o_write, o_rx_line_done, o_line_len, o_overflow, o_busy} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got addr=%h data=%h wr=%b done=%b len=%0d ovf=%b busy=%b, need all 0",
                  o_addr, o_data, o_write, o_rx_line_done, o_line_len, o_overflow, o_busy);
      end
      reset = 1'b0;
      wr_log.delete();
      do_start(8'h30);
      tick(3);
      rx_done = 1'b0;
      tick(2);
      total++;
      if (wr_log.size() !== 0) begin
         bad++;
         $display("FAIL held_rx_done: got %0d writes, need 0", wr_log.size());
      end
      total++;
      if (o_busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_after_start: got %b, need 1", o_busy);
      end
   endtask

   task automatic test_basic();
      bq_t s;
      s = '{8'h41, 8'h44, 8'h41, 8'h4D, 8'h0D};
      run_line(8'h01, s);
      total++;
      if (log_diff() !== 0) begin bad++; $display("FAIL basic_writes: got %0d writes, need %0d", wr_log.size(), exp_wr.size()); end
      total++;
      if (ram_diff() !== 0) begin bad++; $display("FAIL basic_ram: got %0d bytes differing, need 0", ram_diff()); end
      total++;
      if ({o_rx_line_done, o_overflow, o_busy} !== 3'b100) begin
         bad++; $display("FAIL basic_flags: got done/ovf/busy=%b%b%b, need 100", o_rx_line_done, o_overflow, o_busy);
      end
      total++;
      if (o_line_len !== LW'(exp_len) || exp_len != 4) begin
         bad++; $display("FAIL basic_len: got %0d, need 4", o_line_len);
      end
   endtask

   task automatic test_edit();
      bq_t s;
      s = '{8'h41, 8'h42, 8'h08, 8'h43, 8'h7F, 8'h7F, 8'h7F, 8'h44, 8'h0D};
      run_line(8'h10, s);
      total++;
      if (log_diff() !== 0) begin bad++; $display("FAIL edit_writes: got %0d writes, need %0d", wr_log.size(), exp_wr.size()); end
      total++;
      if (ram_diff() !== 0 || ram[8'h10] !== 8'h44 || ram[8'h11] !== 8'h00) begin
         bad++; $display("FAIL edit_ram: got RAM[10]=%h RAM[11]=%h, need 44 00", ram[8'h10], ram[8'h11]);
      end
      total++;
      if (o_line_len !== LW'(1) || o_rx_line_done !== 1'b1) begin
         bad++; $display("FAIL edit_len: got len=%0d done=%b, need 1 1", o_line_len, o_rx_line_done);
      end
   endtask

   task automatic test_overflow();
      bq_t s;
      s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D};
      run_line(8'h40, s);
      total++;
      if (log_diff() !== 0) begin bad++; $display("FAIL ovf_writes: got %0d writes, need %0d", wr_log.size(), exp_wr.size()); end
      total++;
      if (ram_diff() !== 0 || ram[8'h46] !== 8'h00) begin
         bad++; $display("FAIL ovf_ram: got RAM[46]=%h, need 00", ram[8'h46]);
      end
      total++;
      if (o_overflow !== 1'b1 || o_line_len !== LW'(MAXL)) begin
         bad++; $display("FAIL ovf_flag: got ovf=%b len=%0d, need 1 %0d", o_overflow, o_line_len, MAXL);
      end
   endtask

   task automatic test_wrap();
      bq_t s;
      s = '{8'h41, 8'h42, 8'h43, 8'h0D};
      run_line(8'hFE, s);
      total++;
      if (wr_log.size() !== 4 || wr_log[2] !== 16'h0043 || wr_log[3] !== 16'h0100) begin
         bad++; $display("FAIL wrap_writes: got %0d writes, need FE:41 FF:42 00:43 01:00", wr_log.size());
      end
      total++;
      if (ram_diff() !== 0) begin bad++; $display("FAIL wrap_ram: got %0d bytes differing, need 0", ram_diff()); end
   endtask

   task automatic test_lf_and_done();
      bq_t s;
      s = '{8'h41, 8'h0A, 8'h42, 8'h0D};
      run_line(8'h20, s);
      total++;
      if (log_diff() !== 0 || o_line_len !== LW'(2)) begin
         bad++; $display("FAIL lf_line: got %0d writes len=%0d, need %0d writes len 2", wr_log.size(), o_line_len, exp_wr.size());
      end
      wr_log.delete();
      send_byte(8'h43);
      send_byte(8'h0D);
      tick(2);
      total++;
      if (wr_log.size() !== 0 || o_rx_line_done !== 1'b1 || o_line_len !== LW'(2)) begin
         bad++; $display("FAIL after_done: got %0d writes done=%b len=%0d, need 0 1 2", wr_log.size(), o_rx_line_done, o_line_len);
      end
   endtask

   task automatic test_abort();
      bq_t s;
      s = '{8'h41, 8'h42};
      run_line(8'h50, s);
      reset = 1'b1;
      tick(1);
      total++;
      if ({o_addr, o_data, o_write, o_rx_line_done, o_line_len, o_overflow, o_busy} !== '0) begin
         bad++; $display("FAIL abort_outputs: got addr=%h data=%h busy=%b, need all 0", o_addr, o_data, o_busy);
      end
      reset = 1'b0;
      tick(2);
      total++;
      if (ram_diff() !== 0 || ram[8'h52] !== 8'hEE) begin
         bad++; $display("FAIL abort_ram: got RAM[52]=%h, need EE", ram[8'h52]);
      end
      s = '{8'h55, 8'h56, 8'h0D};
      run_line(8'h60, s);
      total++;
      if (log_diff() !== 0 || ram_diff() !== 0 || o_line_len !== LW'(2)) begin
         bad++; $display("FAIL abort_restart: got %0d writes len=%0d, need %0d writes len 2", wr_log.size(), o_line_len, exp_wr.size());
      end
   endtask

   task automatic test_back_to_back();
      bq_t s;
      s = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
      run_line(8'h70, s);
      total++;
      if (o_overflow !== 1'b1 || o_busy !== 1'b1) begin
         bad++; $display("FAIL b2b_partial: got ovf=%b busy=%b, need 1 1", o_overflow, o_busy);
      end
      // restart mid-line with a byte arriving in the start cycle
      wr_log.delete();
      rx_data = 8'h5A; rx_done = 1'b1; start = 1'b1; start_addr = 8'h78;
      tick(1);
      start = 1'b0;
      tick(1);
      rx_done = 1'b0;
      tick(1);
      s = '{8'h43, 8'h0D};
      foreach (s[i]) send_byte(s[i]);
      tick(2);
      model_line(8'h78, s);
      total++;
      if (log_diff() !== 0 || ram_diff() !== 0) begin
         bad++; $display("FAIL b2b_restart: got %0d writes, need %0d", wr_log.size(), exp_wr.size());
      end
      total++;
      if (o_overflow !== 1'b0 || o_line_len !== LW'(1)) begin
         bad++; $display("FAIL b2b_flags: got ovf=%b len=%0d, need 0 1", o_overflow, o_line_len);
      end
   endtask

   task automatic test_random();
      bq_t s;
      logic [7:0] pool[$];
      logic [7:0] base;
      int nbad = 0;
      pool = '{8'h08, 8'h7F, 8'h0A, 8'h30, 8'h41, 8'h5A, 8'h61, 8'h7E, 8'h00, 8'hFF};
      for (int n = 0; n < 25; n++) begin
         s.delete();
         for (int k = 0; k < int'($urandom_range(0, 10)); k++)
            s.push_back(($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 9)] : 8'($urandom_range(8'h20, 8'h7E)));
         for (int k = 0; k < s.size(); k++) if (s[k] == 8'h0D) s[k] = 8'h2E;
         s.push_back(8'h0D);
         base = 8'($urandom);
         run_line(base, s);
         total++;
         if (log_diff() !== 0 || ram_diff() !== 0) begin
            bad++; $display("FAIL rand_data[%0d]: got %0d writes, need %0d", n, wr_log.size(), exp_wr.size());
         end
         total++;
         if ({o_rx_line_done, o_overflow, o_line_len} !== {1'b1, exp_ovf, LW'(exp_len)}) begin
            bad++; $display("FAIL rand_status[%0d]: got done=%b ovf=%b len=%0d, need 1 %b %0d",
                            n, o_rx_line_done, o_overflow, o_line_len, exp_ovf, exp_len);
         end
      end
      total++;
      if (consec !== 1'b0) begin bad++; $display("FAIL write_spacing: got back-to-back strobes, need none"); end
      nbad = ram_diff();
      total++;
      if (nbad !== 0) begin bad++; $display("FAIL final_ram: got %0d bytes differing, need 0", nbad); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]     = 8'hEE;
         exp_ram[i] = 8'hEE;
      end
      test_reset();
      test_basic();
      test_edit();
      test_overflow();
      test_wrap();
      test_lf_and_done();
      test_abort();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, need finish before time limit");
      $fatal(1);
   end

endmodule
